// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator for VGA-style displays. Produces the
//               pixel column/line counters, registered sync pulses, the
//               visible-area flag and start-of-line / start-of-frame ticks.
//               All outputs come from flops and change together, so the
//               counts, syncs and video_on are always mutually consistent.
//
// Ports       : clk        - pixel-domain clock, rising edge
//               rst_n      - asynchronous active-low reset
//               pix_ce     - pixel clock enable; counters advance only when 1
//               h_count    - current pixel column (0 .. H_TOTAL-1)
//               v_count    - current line (0 .. V_TOTAL-1)
//               hsync      - horizontal sync, active level HS_POL
//               vsync      - vertical sync, active level VS_POL
//               video_on   - 1 while (h_count, v_count) is in the visible area
//               line_tick  - one-cycle pulse on the first cycle of each line
//               frame_tick - one-cycle pulse on the first cycle of each frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_VIS  = 800,
    parameter int   H_FP   = 40,
    parameter int   H_SYNC = 128,
    parameter int   H_BP   = 88,
    parameter int   V_VIS  = 600,
    parameter int   V_FP   = 1,
    parameter int   V_SYNC = 4,
    parameter int   V_BP   = 23,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    output logic [10:0] h_count,
    output logic [10:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_tick,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Region boundaries are kept one bit wider than the counters so that a
    // boundary equal to 2048 still compares correctly.
    localparam logic [11:0] C_H_VIS      = 12'(H_VIS);
    localparam logic [11:0] C_HS_START   = 12'(H_VIS + H_FP);
    localparam logic [11:0] C_HS_END     = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] C_V_VIS      = 12'(V_VIS);
    localparam logic [11:0] C_VS_START   = 12'(V_VIS + V_FP);
    localparam logic [11:0] C_VS_END     = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] C_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST     = 11'(V_TOTAL - 1);

    // Counters are 11 bits wide, so neither total may exceed 2048.
    if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic        line_tick_q, line_tick_d;
    logic        frame_tick_q, frame_tick_d;
    logic        h_wrap;
    logic        v_wrap;

    always_comb begin
        h_wrap = (h_q == C_H_LAST);
        v_wrap = (v_q == C_V_LAST);

        h_d = h_q;
        v_d = v_q;
        if (pix_ce) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end

        // Decoding the *next* counts lets the registered flags line up with
        // the registered counts in the same cycle. With pix_ce low the next
        // counts equal the current ones, so the flags hold naturally.
        hsync_d = (({1'b0, h_d} >= C_HS_START) && ({1'b0, h_d} < C_HS_END))
                  ? HS_POL : ~HS_POL;
        vsync_d = (({1'b0, v_d} >= C_VS_START) && ({1'b0, v_d} < C_VS_END))
                  ? VS_POL : ~VS_POL;
        video_on_d = ({1'b0, h_d} < C_H_VIS) && ({1'b0, v_d} < C_V_VIS);

        // Ticks fire only on the advancing edge that performs the wrap, so a
        // count held at 0 by pix_ce=0 does not stretch the pulse.
        line_tick_d  = pix_ce & h_wrap;
        frame_tick_d = pix_ce & h_wrap & v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            video_on_q   <= 1'b1;    // (0, 0) is inside the visible area
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign h_count    = h_q;
    assign v_count    = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign line_tick  = line_tick_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
